dlf_iir_seq: RTL and testbench

Next-generation ADPLL digital loop filter: an IIR of parametrised order with a single time-multiplexed multiply-accumulate, runtime-writable coefficients, a valid/ready sample handshake, a hold (freeze) mode, rounding and output saturation. It sits between the phase-error quantiser output (magnitude plus lead flag) and the DCO control word. Computes y[n] = sum b_k*x[n-k] (k=0..ORDER) - sum a_k*y[n-k] (k=1..ORDER).

---
 rtl/dlf_iir_seq_pkg.sv | 57 +++++
 rtl/dlf_iir_seq_if.sv | 30 +++
 rtl/dlf_iir_seq_coef_regfile.sv | 47 ++++
 rtl/dlf_iir_seq.sv | 155 +++++++++++++++
 tb/tb_dlf_iir_seq.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/dlf_iir_seq_pkg.sv
// Shared types and constants for the ADPLL loop filter: width helpers,
// reset coefficients, coefficient address map and the sequencer states.
package dlf_pkg;

    localparam int DEF_COEF_W = 20;

    // Reset coefficients, Q2.18
    localparam logic [DEF_COEF_W-1:0] DEF_B0 = 20'h00A00;
    localparam logic [DEF_COEF_W-1:0] DEF_B1 = 20'h00A63;
    localparam logic [DEF_COEF_W-1:0] DEF_B2 = 20'hFF6C5;
    localparam logic [DEF_COEF_W-1:0] DEF_B3 = 20'hFF662;
    localparam logic [DEF_COEF_W-1:0] DEF_A1 = 20'h96E98;
    localparam logic [DEF_COEF_W-1:0] DEF_A2 = 20'h2D1AF;
    localparam logic [DEF_COEF_W-1:0] DEF_A3 = 20'hFBFC3;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    function automatic int coef_w(int int_w, int frac_w);
        return int_w + frac_w;
    endfunction

    function automatic int acc_w(int in_w, int out_w, int cw, int guard);
        return ((in_w > out_w) ? in_w : out_w) + 1 + cw + guard;
    endfunction

    // Address map: b0..bORDER first, then a1..aORDER
    function automatic int b_addr(int k);
        return k;
    endfunction

    function automatic int a_addr(int order, int k);
        return order + k;
    endfunction

    function automatic logic [DEF_COEF_W-1:0] def_coef(int order, int addr);
        logic [DEF_COEF_W-1:0] c;
        c = '0;
        if (addr <= order) begin
            case (addr)
                0:       c = DEF_B0;
                1:       c = DEF_B1;
                2:       c = DEF_B2;
                3:       c = DEF_B3;
                default: c = '0;
            endcase
        end else begin
            case (addr - order)
                1:       c = DEF_A1;
                2:       c = DEF_A2;
                3:       c = DEF_A3;
                default: c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/dlf_iir_seq_if.sv
// Sample handshake, coefficient write port and DCO word output of the loop filter.
interface dlf_iir_seq_if #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 8,
    parameter int COEF_W = 20,
    parameter int AW     = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic [IN_W-1:0]          master_in;
    logic                     lead;
    logic                     hold;
    logic                     coef_wr_en;
    logic [AW-1:0]            coef_wr_addr;
    logic signed [COEF_W-1:0] coef_wr_data;
    logic                     coef_wr_err;
    logic                     out_valid;
    logic [OUT_W-1:0]         slave_out;
    logic                     sat_flag;

    modport slave (
        input  in_valid, master_in, lead, hold, coef_wr_en, coef_wr_addr, coef_wr_data,
        output in_ready, coef_wr_err, out_valid, slave_out, sat_flag
    );

    modport master (
        output in_valid, master_in, lead, hold, coef_wr_en, coef_wr_addr, coef_wr_data,
        input  in_ready, coef_wr_err, out_valid, slave_out, sat_flag
    );
endinterface

// File: rtl/dlf_iir_seq_coef_regfile.sv
// Coefficient store: b0..bORDER, a1..aORDER with reset defaults; writes are
// refused while the sequencer is busy or the address is out of range.
module dlf_coef_regfile
    import dlf_pkg::*;
#(
    parameter int ORDER  = 3,
    parameter int COEF_W = 20,
    parameter int AW     = $clog2(2*ORDER+1)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic signed [COEF_W-1:0] wr_data,
    input  logic                     busy,
    output logic                     wr_err,
    input  logic [AW-1:0]            rd_addr,
    output logic signed [COEF_W-1:0] rd_data
);
    localparam int NREG = 2*ORDER + 1;

    logic signed [COEF_W-1:0] regs [NREG];
    logic                     wr_ok;

    assign wr_ok = !busy && (int'(wr_addr) < NREG);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_err <= 1'b0;
            for (int i = 0; i < NREG; i++)
                regs[i] <= COEF_W'($signed(def_coef(ORDER, i)));
        end else begin
            wr_err <= wr_en && !wr_ok;
            for (int i = 0; i < NREG; i++)
                if (wr_en && wr_ok && wr_addr == AW'(i))
                    regs[i] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NREG; i++)
            if (rd_addr == AW'(i))
                rd_data = regs[i];
    end

endmodule

// File: rtl/dlf_iir_seq.sv
// ADPLL loop filter: IIR of order ORDER evaluated with one shared MAC,
// one product per cycle, then rounding, saturation and clamp to the DCO word.
module dlf_iir_seq
    import dlf_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int OUT_W       = 8,
    parameter int ORDER       = 3,
    parameter int COEF_INT_W  = 2,
    parameter int COEF_FRAC_W = 18,
    parameter int ACC_GUARD   = 4
) (
    input  logic          clk,
    input  logic          rstn,
    dlf_iir_seq_if.slave  bus
);
    localparam int COEF_W = coef_w(COEF_INT_W, COEF_FRAC_W);
    localparam int ACC_W  = acc_w(IN_W, OUT_W, COEF_W, ACC_GUARD);
    localparam int AW     = $clog2(2*ORDER+1);
    localparam int DW     = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;
    localparam int PW     = DW + COEF_W;
    localparam int YW     = ACC_W - COEF_FRAC_W;
    localparam logic [AW-1:0]          LAST = AW'(2*ORDER);
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (COEF_FRAC_W-1);
    localparam logic signed [YW-1:0]   Y_HI = YW'(2**OUT_W - 1);
    localparam logic signed [YW-1:0]   Y_LO = ~Y_HI;

    state_t                   state, nstate;
    logic [AW-1:0]            idx;
    logic signed [ACC_W-1:0]  acc, acc_rnd, prod_ext;
    logic signed [IN_W:0]     x_cur, x_in;
    logic                     hold_q;
    logic signed [IN_W:0]     xh [ORDER];
    logic signed [OUT_W:0]    yh [ORDER];
    logic signed [DW-1:0]     opnd;
    logic                     sub;
    logic signed [COEF_W-1:0] coef;
    logic signed [PW-1:0]     prod;
    logic signed [YW-1:0]     y_full;
    logic signed [OUT_W:0]    y_sat;
    logic                     y_ovf, y_clip;
    logic [OUT_W-1:0]         y_out;
    logic                     accept;

    assign bus.in_ready = (state == S_IDLE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign x_in         = bus.lead ? $signed({1'b0, bus.master_in})
                                   : -$signed({1'b0, bus.master_in});

    dlf_coef_regfile #(.ORDER(ORDER), .COEF_W(COEF_W), .AW(AW)) u_coef (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (bus.coef_wr_en),
        .wr_addr (bus.coef_wr_addr),
        .wr_data (bus.coef_wr_data),
        .busy    (!bus.in_ready),
        .wr_err  (bus.coef_wr_err),
        .rd_addr (idx),
        .rd_data (coef)
    );

    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (accept) nstate = bus.hold ? S_OUT : S_MAC;
            S_MAC:   if (idx == LAST) nstate = S_OUT;
            S_OUT:   nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // Data operand follows the coefficient address map; feedback terms subtract
    always_comb begin
        opnd = DW'(x_cur);
        sub  = 1'b0;
        for (int k = 1; k <= ORDER; k++) begin
            if (idx == AW'(b_addr(k))) opnd = DW'(xh[k-1]);
            if (idx == AW'(a_addr(ORDER, k))) begin
                opnd = DW'(yh[k-1]);
                sub  = 1'b1;
            end
        end
    end

    assign prod     = coef * opnd;
    assign prod_ext = ACC_W'(prod);
    assign acc_rnd  = acc + RND;
    assign y_full   = acc_rnd[ACC_W-1:COEF_FRAC_W];

    always_comb begin
        y_ovf = 1'b0;
        y_sat = y_full[OUT_W:0];
        if (y_full > Y_HI) begin
            y_sat = {1'b0, {OUT_W{1'b1}}};
            y_ovf = 1'b1;
        end else if (y_full < Y_LO) begin
            y_sat = {1'b1, {OUT_W{1'b0}}};
            y_ovf = 1'b1;
        end
        y_clip = y_sat[OUT_W];
        y_out  = y_clip ? '0 : y_sat[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx           <= '0;
            acc           <= '0;
            x_cur         <= '0;
            hold_q        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.slave_out <= '0;
            bus.sat_flag  <= 1'b0;
            for (int k = 0; k < ORDER; k++) begin
                xh[k] <= '0;
                yh[k] <= '0;
            end
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    x_cur  <= x_in;
                    hold_q <= bus.hold;
                    acc    <= '0;
                    idx    <= '0;
                end
                S_MAC: begin
                    acc <= sub ? acc - prod_ext : acc + prod_ext;
                    idx <= idx + 1'b1;
                end
                S_OUT: begin
                    bus.out_valid <= 1'b1;
                    bus.sat_flag  <= 1'b0;
                    // A held sample leaves every piece of filter state untouched
                    if (!hold_q) begin
                        xh[0] <= x_cur;
                        yh[0] <= y_sat;
                        for (int k = 1; k < ORDER; k++) begin
                            xh[k] <= xh[k-1];
                            yh[k] <= yh[k-1];
                        end
                        bus.slave_out <= y_out;
                        bus.sat_flag  <= y_ovf | y_clip;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dlf_iir_seq.sv
// Directed bench for dlf_iir_seq: hand-computed vectors plus a Q2.18
// difference-equation reference for the default-coefficient step response.
module tb_dlf_iir_seq;
    logic clk = 1'b0;
    logic rstn;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dlf_iir_seq_if #(.IN_W(8), .OUT_W(8), .COEF_W(20), .AW(3)) bus ();

    dlf_iir_seq dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    longint bm [4];
    longint am [4];
    longint xm [3];
    longint ym [3];

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input longint x, output int o, output int s);
        longint acc, y;
        acc = bm[0] * x;
        for (int k = 1; k <= 3; k++)
            acc = acc + bm[k] * xm[k-1] - am[k] * ym[k-1];
        y = (acc + 64'sd131072) >>> 18;
        s = 0;
        if (y > 255) begin y = 255; s = 1; end
        else if (y < -256) begin y = -256; s = 1; end
        xm[2] = xm[1]; xm[1] = xm[0]; xm[0] = x;
        ym[2] = ym[1]; ym[1] = ym[0]; ym[0] = y;
        if (y < 0) begin o = 0; s = 1; end
        else o = int'(y);
    endtask

    task automatic do_reset();
        rstn             = 1'b0;
        bus.in_valid     = 1'b0;
        bus.master_in    = '0;
        bus.lead         = 1'b0;
        bus.hold         = 1'b0;
        bus.coef_wr_en   = 1'b0;
        bus.coef_wr_addr = '0;
        bus.coef_wr_data = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic wr_coef(input logic [2:0] addr, input logic [19:0] data, input int exp_err);
        bus.coef_wr_en   = 1'b1;
        bus.coef_wr_addr = addr;
        bus.coef_wr_data = data;
        @(posedge clk); #1;
        bus.coef_wr_en = 1'b0;
        chk("wr_err", bus.coef_wr_err, exp_err);
    endtask

    task automatic set7(input logic [19:0] c0, c1, c2, c3, c4, c5, c6);
        wr_coef(3'd0, c0, 0); wr_coef(3'd1, c1, 0); wr_coef(3'd2, c2, 0);
        wr_coef(3'd3, c3, 0); wr_coef(3'd4, c4, 0); wr_coef(3'd5, c5, 0);
        wr_coef(3'd6, c6, 0);
    endtask

    // Offers one sample and waits for its result; keep leaves in_valid high
    // through the computation, mid tries a b0 write while the MAC runs.
    task automatic send(input int mag, input bit ld, input bit hd, input bit keep, input bit mid,
                        input string tag, input int exp_out, input int exp_sat, input int exp_lat);
        int n;
        logic [31:0] m;
        n = 0;
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk({tag, "_rdy"}, bus.in_ready, 1);
        m             = mag;
        bus.master_in = m[7:0];
        bus.lead      = ld;
        bus.hold      = hd;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.coef_wr_en = 1'b0;
        if (!keep) bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 30) begin
            if (mid && n == 2) begin
                bus.coef_wr_en   = 1'b1;
                bus.coef_wr_addr = 3'd0;
                bus.coef_wr_data = 20'h20000;
            end
            if (mid && n == 3) begin
                chk({tag, "_busy_err"}, bus.coef_wr_err, 1);
                bus.coef_wr_en = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        bus.hold     = 1'b0;
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_out"}, bus.slave_out, exp_out);
        chk({tag, "_sat"}, bus.sat_flag, exp_sat);
    endtask

    task automatic watch(input string tag, input int cycles, input int exp_cnt);
        int c;
        c = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) c++;
        end
        chk(tag, c, exp_cnt);
    endtask

    initial begin
        int eo, es, last;

        do_reset();
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_out",   bus.slave_out, 0);
        chk("rst_sat",   bus.sat_flag, 0);
        chk("rst_err",   bus.coef_wr_err, 0);

        // Pass-through, b0 = 1.0
        set7(20'h40000, 0, 0, 0, 0, 0, 0);
        send(100, 1, 0, 0, 0, "pass_pos", 100, 0, 8);
        send(100, 0, 0, 0, 0, "pass_neg", 0, 1, 8);
        wr_coef(3'd7, 20'h12345, 1);
        send(50, 1, 0, 0, 1, "busy_wr", 50, 0, 8);
        send(50, 1, 0, 0, 0, "b0_kept", 50, 0, 8);
        bus.coef_wr_en   = 1'b1;
        bus.coef_wr_addr = 3'd0;
        bus.coef_wr_data = 20'h20000;
        send(100, 1, 0, 0, 0, "same_edge", 50, 0, 8);
        send(100, 1, 0, 1, 0, "held_valid", 50, 0, 8);
        watch("held_valid_extra", 20, 0);

        // Integrator: y = x + y[n-1]
        do_reset();
        set7(20'h40000, 0, 0, 0, 20'hC0000, 0, 0);
        send(100, 1, 0, 0, 0, "int1", 100, 0, 8);
        send(100, 1, 0, 0, 0, "int2", 200, 0, 8);
        send(100, 1, 0, 0, 0, "int3", 255, 1, 8);
        send(100, 0, 0, 0, 0, "int4", 155, 0, 8);

        // Rounding, b0 = 0.5
        do_reset();
        set7(20'h20000, 0, 0, 0, 0, 0, 0);
        send(3, 1, 0, 0, 0, "rnd_pos", 2, 0, 8);
        send(3, 0, 0, 0, 0, "rnd_neg", 0, 1, 8);

        // Default coefficients: step response against the reference
        do_reset();
        bm = '{2560, 2659, -2363, -2462};
        am = '{0, -430440, 184751, -16445};
        xm = '{0, 0, 0};
        ym = '{0, 0, 0};
        model_step(100, eo, es);
        send(100, 1, 0, 0, 0, "dflt0", 1, 0, 8);
        last = 1;
        for (int i = 1; i <= 5; i++) begin
            model_step(100, eo, es);
            send(100, 1, 0, 0, 0, $sformatf("step%0d", i), eo, es, 8);
            last = eo;
        end
        send(50, 1, 1, 0, 0, "hold", last, 0, 1);
        model_step(100, eo, es);
        send(100, 1, 0, 0, 0, "post_hold", eo, es, 8);

        // Reset at E3 of a sample in flight
        do_reset();
        set7(20'h40000, 0, 0, 0, 0, 0, 0);
        send(100, 1, 0, 0, 0, "pre_rst", 100, 0, 8);
        bus.master_in = 8'd100;
        bus.lead      = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        chk("abort_out", bus.slave_out, 0);
        chk("abort_ready", bus.in_ready, 1);
        watch("abort_valid", 15, 0);
        send(100, 1, 0, 0, 0, "dflt_after_rst", 1, 0, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
